sc_carposition_shifter: RTL and testbench
=========================================

Name: sc_carposition_shifter

Overview:
- Produces the player car's one-hot lateral position bus, the same bus the side comparator decodes into edge flags.
- Takes the left/right buttons, which are already synchronized and debounced. Makes one move per press, then auto-repeats while a button is held. Saturates at the track edges.
- Sits between the button-input stage and the matrix-render/side-comparator logic in the game datapath.

Parameters:
- CARPOSITION_DATAWIDTH, 4, width of the position bus. Bit [W-1] is the leftmost lane, bit 0 the rightmost.
- CARPOSITION_INIT, 4'b0010, position loaded on reset/clear. Must be one-hot; any other value is illegal.
- CARPOSITION_REPEAT, 4, clock cycles between auto-repeat moves while a button is held. Must be ≥2.

Ports:
- SC_CARPOSITION_CLOCK_50  in  1  system clock
- SC_CARPOSITION_RESET_InHigh  in  1  reset, synchronous, active-high
- SC_CARPOSITION_clear_InHigh  in  1  synchronous reload to INIT (game restart)
- SC_CARPOSITION_enable_InHigh  in  1  game running; low freezes position
- SC_CARPOSITION_left_InLow  in  1  left button, active-low
- SC_CARPOSITION_right_InLow  in  1  right button, active-low
- SC_CARPOSITION_data_OutBUS  out  W  registered one-hot car position
- SC_CARPOSITION_side_L_OutLow  out  1  low while position == 1000 (MSB set)
- SC_CARPOSITION_side_R_OutLow  out  1  low while position == 0001 (LSB set)
- SC_CARPOSITION_moved_OutHigh  out  1  one-cycle pulse when position actually changed

Behaviour:
- Clock and reset: single clock SC_CARPOSITION_CLOCK_50. Reset is synchronous, active-high, and has the highest priority. Priority order: RESET > clear > enable low > buttons.
- Reset/clear values: data = INIT, moved = 0, side flags decoded from INIT (1/1 for the default), repeat counter = 0, state = WAIT_RELEASE.
- Moves: left = shift toward MSB (data<<1); right = shift toward LSB (data>>1).
  - A left move at 1000 or a right move at 0001 leaves data unchanged and moved = 0.
  - The bus is always exactly one-hot.
- Output timing:
  - Side flags are registered on the same edge as data, so they are always consistent with data_OutBUS.
  - moved is registered; it is high for the one cycle following the edge at which data changed.
- Repeat counter: width $clog2(REPEAT+1); cleared on every state entry.
- FSM states: WAIT_RELEASE, IDLE, HOLD_L, HOLD_R, BOTH. Button codes below are (left, right).
- WAIT_RELEASE: no moves. Goes to IDLE on an edge where both buttons are released (1,1) and enable = 1.
- IDLE:
  - (0,1) → move left on this edge, go to HOLD_L.
  - (1,0) → move right, go to HOLD_R.
  - (0,0) → BOTH, no move.
  - (1,1) → stay.
- HOLD_L:
  - Left still held, right released: counter increments each edge. On the edge where counter == REPEAT-1: move left, counter = 0. Repeat moves are therefore spaced REPEAT cycles apart, the first one REPEAT cycles after the initial move.
  - (1,1) → IDLE.
  - (0,0) → BOTH.
  - (1,0) (left released and right pressed on the same edge) → treated as a fresh right press: immediate right move, go to HOLD_R.
- HOLD_R: mirror image of HOLD_L.
- BOTH:
  - No moves.
  - (1,1) → IDLE.
  - One button released (other still held) → HOLD_x of the remaining button with counter = 0 and no immediate move. The first move comes after REPEAT cycles.
- enable low:
  - On any edge: data held, moved = 0, counter = 0, state → WAIT_RELEASE.
  - Any button held through enable/clear/reset must be released before it takes effect.
- Mid-hold clear: position reloads immediately, and any pending repeat is discarded.

Test Plan:
- Reset asserted 2 cycles → data = 0010, side_L/R = 1/1, moved = 0. Buttons idle 1 cycle → state IDLE.
- Left taps (1 cycle each, released between): data 0010 → 0100 → 1000, moved pulses once per tap, side_L = 0 at 1000. Third tap: data stays 1000, moved stays 0.
- From 0010, hold left 9 cycles (REPEAT = 4) → move at edge 1 (0100) and at edge 5 (1000). At edge 9 (saturated), no change and no moved pulse. Release → IDLE.
- Press both for 3 cycles → no change. Release left, keep right → first right move exactly 4 edges later, then every 4.
- Hold left, assert clear for 1 cycle mid-hold → data = 0010 next cycle, no moves while left remains held. Release then press → one immediate move to 0100.
- enable = 0, toggle both buttons for 20 cycles → data and side flags constant, moved = 0. Set enable = 1 with right held → no move until right released and re-pressed.

Source files
------------

// File: rtl/sc_carposition_shifter.sv
// Player-car lateral position shifter.
// Buttons give one move per press, then auto-repeat while held.
// The one-hot position saturates at the track edges.
//
// Ports:
//   SC_CARPOSITION_CLOCK_50       system clock
//   SC_CARPOSITION_RESET_InHigh   synchronous reset, active-high
//   SC_CARPOSITION_clear_InHigh   synchronous reload to INIT
//   SC_CARPOSITION_enable_InHigh  game running; low freezes the position
//   SC_CARPOSITION_left_InLow     left button, active-low
//   SC_CARPOSITION_right_InLow    right button, active-low
//   SC_CARPOSITION_data_OutBUS    registered one-hot position (MSB = leftmost lane)
//   SC_CARPOSITION_side_L_OutLow  low while the car is in the leftmost lane
//   SC_CARPOSITION_side_R_OutLow  low while the car is in the rightmost lane
//   SC_CARPOSITION_moved_OutHigh  one-cycle pulse after the position changed
module sc_carposition_shifter #(
    parameter int CARPOSITION_DATAWIDTH = 4,
    parameter logic [CARPOSITION_DATAWIDTH-1:0] CARPOSITION_INIT = 4'b0010,
    parameter int CARPOSITION_REPEAT = 4
) (
    input  logic                             SC_CARPOSITION_CLOCK_50,
    input  logic                             SC_CARPOSITION_RESET_InHigh,
    input  logic                             SC_CARPOSITION_clear_InHigh,
    input  logic                             SC_CARPOSITION_enable_InHigh,
    input  logic                             SC_CARPOSITION_left_InLow,
    input  logic                             SC_CARPOSITION_right_InLow,
    output logic [CARPOSITION_DATAWIDTH-1:0] SC_CARPOSITION_data_OutBUS,
    output logic                             SC_CARPOSITION_side_L_OutLow,
    output logic                             SC_CARPOSITION_side_R_OutLow,
    output logic                             SC_CARPOSITION_moved_OutHigh
);

    localparam int W  = CARPOSITION_DATAWIDTH;
    localparam int CW = $clog2(CARPOSITION_REPEAT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CARPOSITION_REPEAT - 1);

    typedef enum logic [2:0] {
        S_WAIT_RELEASE,
        S_IDLE,
        S_HOLD_L,
        S_HOLD_R,
        S_BOTH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic          moved_q, moved_d;
    logic          side_l_q, side_l_d;
    logic          side_r_q, side_r_d;

    logic btn_l, btn_r;
    logic mv_l, mv_r;

    assign btn_l = ~SC_CARPOSITION_left_InLow;
    assign btn_r = ~SC_CARPOSITION_right_InLow;

    // State register
    always_ff @(posedge SC_CARPOSITION_CLOCK_50) begin
        if (SC_CARPOSITION_RESET_InHigh) begin
            state_q  <= S_WAIT_RELEASE;
            cnt_q    <= '0;
            data_q   <= CARPOSITION_INIT;
            moved_q  <= 1'b0;
            side_l_q <= ~CARPOSITION_INIT[W-1];
            side_r_q <= ~CARPOSITION_INIT[0];
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            moved_q  <= moved_d;
            side_l_q <= side_l_d;
            side_r_q <= side_r_d;
        end
    end

    // Next state, repeat counter and move requests.
    // The counter defaults to zero so every state entry clears it.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mv_l    = 1'b0;
        mv_r    = 1'b0;
        if (SC_CARPOSITION_clear_InHigh || !SC_CARPOSITION_enable_InHigh) begin
            state_d = S_WAIT_RELEASE;
        end else begin
            case (state_q)
                S_WAIT_RELEASE: begin
                    if (!btn_l && !btn_r) state_d = S_IDLE;
                end
                S_IDLE: begin
                    case ({btn_l, btn_r})
                        2'b10: begin mv_l = 1'b1; state_d = S_HOLD_L; end
                        2'b01: begin mv_r = 1'b1; state_d = S_HOLD_R; end
                        2'b11: state_d = S_BOTH;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_HOLD_L: begin
                    case ({btn_l, btn_r})
                        2'b10: begin
                            if (cnt_q == CNT_LAST) mv_l = 1'b1;
                            else cnt_d = cnt_q + 1'b1;
                        end
                        2'b01: begin mv_r = 1'b1; state_d = S_HOLD_R; end
                        2'b11: state_d = S_BOTH;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_HOLD_R: begin
                    case ({btn_l, btn_r})
                        2'b01: begin
                            if (cnt_q == CNT_LAST) mv_r = 1'b1;
                            else cnt_d = cnt_q + 1'b1;
                        end
                        2'b10: begin mv_l = 1'b1; state_d = S_HOLD_L; end
                        2'b11: state_d = S_BOTH;
                        default: state_d = S_IDLE;
                    endcase
                end
                S_BOTH: begin
                    // Leaving BOTH never moves at once; the first
                    // move waits a full repeat interval.
                    case ({btn_l, btn_r})
                        2'b10: state_d = S_HOLD_L;
                        2'b01: state_d = S_HOLD_R;
                        2'b11: state_d = S_BOTH;
                        default: state_d = S_IDLE;
                    endcase
                end
                default: state_d = S_WAIT_RELEASE;
            endcase
        end
    end

    // Position, moved pulse and edge flags.
    // A move into a wall is swallowed, so moved only fires on change.
    always_comb begin
        data_d  = data_q;
        moved_d = 1'b0;
        if (SC_CARPOSITION_clear_InHigh) begin
            data_d = CARPOSITION_INIT;
        end else if (mv_l && !data_q[W-1]) begin
            data_d  = data_q << 1;
            moved_d = 1'b1;
        end else if (mv_r && !data_q[0]) begin
            data_d  = data_q >> 1;
            moved_d = 1'b1;
        end
        side_l_d = ~data_d[W-1];
        side_r_d = ~data_d[0];
    end

    assign SC_CARPOSITION_data_OutBUS   = data_q;
    assign SC_CARPOSITION_moved_OutHigh = moved_q;
    assign SC_CARPOSITION_side_L_OutLow = side_l_q;
    assign SC_CARPOSITION_side_R_OutLow = side_r_q;

endmodule

// File: tb/tb_sc_carposition_shifter.sv
// Self-checking bench for sc_carposition_shifter.
// Expected outputs go into a scoreboard queue as stimulus is driven.
module tb_sc_carposition_shifter;

    typedef struct {
        logic       l;
        logic       r;
        logic       en;
        logic       clr;
        logic       rst;
        logic [3:0] d;
        logic       m;
    } step_t;

    typedef struct {
        logic [3:0] d;
        logic       m;
        logic       sl;
        logic       sr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       en  = 1'b0;
    logic       left_n  = 1'b1;
    logic       right_n = 1'b1;
    logic [3:0] dout;
    logic       sl, sr, moved;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    sc_carposition_shifter dut (
        .SC_CARPOSITION_CLOCK_50      (clk),
        .SC_CARPOSITION_RESET_InHigh  (rst),
        .SC_CARPOSITION_clear_InHigh  (clr),
        .SC_CARPOSITION_enable_InHigh (en),
        .SC_CARPOSITION_left_InLow    (left_n),
        .SC_CARPOSITION_right_InLow   (right_n),
        .SC_CARPOSITION_data_OutBUS   (dout),
        .SC_CARPOSITION_side_L_OutLow (sl),
        .SC_CARPOSITION_side_R_OutLow (sr),
        .SC_CARPOSITION_moved_OutHigh (moved)
    );

    always #5 clk = ~clk;

    function automatic step_t mk(logic l, logic r, logic e, logic c,
                                 logic rs, logic [3:0] d, logic m);
        step_t s;
        s.l = l; s.r = r; s.en = e; s.clr = c; s.rst = rs;
        s.d = d; s.m = m;
        return s;
    endfunction

    // Drive one cycle of stimulus, queue its expected outcome, and
    // return #1 after the edge that consumes it.
    task automatic apply(input step_t s);
        exp_t e;
        left_n  = ~s.l;
        right_n = ~s.r;
        en      = s.en;
        clr     = s.clr;
        rst     = s.rst;
        e.d  = s.d;
        e.m  = s.m;
        e.sl = (s.d != 4'b1000);
        e.sr = (s.d != 4'b0001);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 4'b0010, 0));
        s.push_back(mk(1, 0, 0, 1, 1, 4'b0010, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0010, 0));
        // First press after idle proves the FSM reached IDLE.
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0100, 0));
        s.push_back(mk(0, 0, 1, 0, 1, 4'b0010, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0010, 0));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if (dout !== e.d || moved !== e.m || sl !== e.sl || sr !== e.sr) begin
                failures++;
                $display("FAIL reset[%0d]: got d=%b m=%b sl=%b sr=%b, want d=%b m=%b sl=%b sr=%b",
                         i, dout, moved, sl, sr, e.d, e.m, e.sl, e.sr);
            end
        end
    endtask

    task automatic test_taps();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0100, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 4'b1000, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b1000, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 4'b1000, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b1000, 0));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if (dout !== e.d || moved !== e.m || sl !== e.sl || sr !== e.sr) begin
                failures++;
                $display("FAIL taps[%0d]: got d=%b m=%b sl=%b sr=%b, want d=%b m=%b sl=%b sr=%b",
                         i, dout, moved, sl, sr, e.d, e.m, e.sl, e.sr);
            end
        end
    endtask

    task automatic test_hold_left();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 0, 1, 1, 0, 4'b0010, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0010, 0));
        for (int k = 1; k <= 9; k++) begin
            if (k == 1)      s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 1));
            else if (k < 5)  s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 0));
            else if (k == 5) s.push_back(mk(1, 0, 1, 0, 0, 4'b1000, 1));
            else             s.push_back(mk(1, 0, 1, 0, 0, 4'b1000, 0));
        end
        s.push_back(mk(0, 0, 1, 0, 0, 4'b1000, 0));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if (dout !== e.d || moved !== e.m || sl !== e.sl || sr !== e.sr) begin
                failures++;
                $display("FAIL hold_left[%0d]: got d=%b m=%b sl=%b sr=%b, want d=%b m=%b sl=%b sr=%b",
                         i, dout, moved, sl, sr, e.d, e.m, e.sl, e.sr);
            end
        end
    endtask

    task automatic test_both();
        step_t s[$];
        exp_t  e;
        logic [3:0] pos;
        logic       mv;
        for (int k = 0; k < 3; k++)
            s.push_back(mk(1, 1, 1, 0, 0, 4'b1000, 0));
        pos = 4'b1000;
        for (int k = 0; k <= 12; k++) begin
            mv = (k != 0) && (k % 4 == 0);
            if (mv) pos = pos >> 1;
            s.push_back(mk(0, 1, 1, 0, 0, pos, mv));
        end
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0001, 0));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if (dout !== e.d || moved !== e.m || sl !== e.sl || sr !== e.sr) begin
                failures++;
                $display("FAIL both[%0d]: got d=%b m=%b sl=%b sr=%b, want d=%b m=%b sl=%b sr=%b",
                         i, dout, moved, sl, sr, e.d, e.m, e.sl, e.sr);
            end
        end
    endtask

    task automatic test_clear_mid_hold();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0010, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0010, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 1));
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 0));
        s.push_back(mk(1, 0, 1, 1, 0, 4'b0010, 0));
        for (int k = 0; k < 6; k++)
            s.push_back(mk(1, 0, 1, 0, 0, 4'b0010, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0010, 0));
        s.push_back(mk(1, 0, 1, 0, 0, 4'b0100, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0100, 0));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if (dout !== e.d || moved !== e.m || sl !== e.sl || sr !== e.sr) begin
                failures++;
                $display("FAIL clear_mid_hold[%0d]: got d=%b m=%b sl=%b sr=%b, want d=%b m=%b sl=%b sr=%b",
                         i, dout, moved, sl, sr, e.d, e.m, e.sl, e.sr);
            end
        end
    endtask

    task automatic test_enable();
        step_t s[$];
        exp_t  e;
        logic [1:0] b;
        for (int k = 0; k < 20; k++) begin
            b = 2'($urandom_range(0, 3));
            s.push_back(mk(b[1], b[0], 0, 0, 0, 4'b0100, 0));
        end
        for (int k = 0; k < 3; k++)
            s.push_back(mk(0, 1, 1, 0, 0, 4'b0100, 0));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0100, 0));
        s.push_back(mk(0, 1, 1, 0, 0, 4'b0010, 1));
        s.push_back(mk(0, 0, 1, 0, 0, 4'b0010, 0));
        foreach (s[i]) begin
            apply(s[i]);
            e = sb.pop_front();
            checks++;
            if (dout !== e.d || moved !== e.m || sl !== e.sl || sr !== e.sr) begin
                failures++;
                $display("FAIL enable[%0d]: got d=%b m=%b sl=%b sr=%b, want d=%b m=%b sl=%b sr=%b",
                         i, dout, moved, sl, sr, e.d, e.m, e.sl, e.sr);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_taps();
        test_hold_left();
        test_both();
        test_clear_mid_hold();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
